fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, ID-stage controls and the
// IF/ID output register, plus the FSM state for observation.
//
// Handshake semantics: imem_req is a single-cycle request pulse qualified by
// imem_addr; the memory answers exactly once with imem_resp_valid (plus
// imem_resp_data) one or more cycles later, and no new request is issued until
// that answer has arrived. valid_if marks inst_if as a real instruction; while
// stall_id is high the ID stage is not ready and the presented instruction is
// held, and it is consumed on the first cycle valid_if=1 and stall_id=0.
// redirect_valid qualifies redirect_pc for one cycle.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_if;
  logic [31:0] pc4_if;
  logic        halted_if;
  logic        valid_if;
  logic [1:0]  fsm_state;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_if, pc4_if, halted_if, valid_if, fsm_state,
    input  imem_resp_valid, imem_resp_data, stall_id, redirect_valid, redirect_pc
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req, imem_addr, inst_if, pc4_if, halted_if, valid_if, fsm_state,
    output imem_resp_valid, imem_resp_data, stall_id, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read at a time, presents the
// returned word to the IF/ID register, honours ID stalls, flushes on
// redirects and stops permanently after fetching the halt word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic         clk,
  input  logic         rst_b,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] redirect_aligned;
  logic [31:0] pc_plus4;

  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
  assign pc_plus4         = pc + 32'd4;

  // A redirect arriving in FETCH suppresses that cycle's request, so a request
  // to the old path never becomes outstanding alongside the redirected one.
  assign bus.imem_req  = (state == FETCH) && !bus.redirect_valid && !rst_b;
  assign bus.imem_addr = pc;
  assign bus.fsm_state = state;

  // Fetch FSM with registered IF/ID outputs
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      bus.inst_if   <= 32'h0;
      bus.pc4_if    <= 32'h0;
      bus.halted_if <= 1'b0;
      bus.valid_if  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.redirect_valid) begin
            pc            <= redirect_aligned;
            bus.inst_if   <= 32'h0;
            bus.valid_if  <= 1'b0;
            bus.halted_if <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (bus.redirect_valid) begin
            pc <= redirect_aligned;
            if (bus.imem_resp_valid) begin
              // The response in flight belongs to the abandoned path.
              kill  <= 1'b0;
              state <= FETCH;
            end else begin
              kill <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= FETCH;
            end else begin
              bus.inst_if   <= bus.imem_resp_data;
              bus.pc4_if    <= pc_plus4;
              bus.valid_if  <= 1'b1;
              bus.halted_if <= (bus.imem_resp_data == HALT_WORD);
              pc            <= {pc_plus4[31:2], 2'b00};
              state         <= PRESENT;
            end
          end
        end

        PRESENT: begin
          if (bus.redirect_valid) begin
            pc            <= redirect_aligned;
            bus.inst_if   <= 32'h0;
            bus.valid_if  <= 1'b0;
            bus.halted_if <= 1'b0;
            state         <= FETCH;
          end else if (!bus.stall_id) begin
            bus.inst_if  <= 32'h0;
            bus.valid_if <= 1'b0;
            state        <= bus.halted_if ? HALT : FETCH;
          end
        end

        HALT: begin
          bus.valid_if  <= 1'b0;
          bus.halted_if <= 1'b1;
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] HALT_WORD = 32'h0000_000C;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory contents for the random run; low bits 2'b11 keep it off HALT_WORD.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0] ^ 30'h1357_9bdf, 2'b11};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.stall_id        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
  endtask

  // Leaves the bench #1 after a rising edge with reset just released,
  // i.e. at the start of the first post-reset cycle.
  task automatic do_reset();
    rst_b = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if, bus.imem_req} !== 67'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b halted=%b inst=%h pc4=%h req=%b, all required 0",
               bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if, bus.imem_req);
    end
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000) begin
      miscompares++;
      $display("FAIL basic_req0: req=%b addr=%h, required 1 00400000", bus.imem_req, bus.imem_addr);
    end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h2008_0005;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0 || bus.valid_if !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait: req=%b valid=%b, required 0 0", bus.imem_req, bus.valid_if);
    end
    tick();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if} !== {2'b10, 32'h2008_0005, 32'h0040_0004}
        || bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_present: valid=%b halted=%b inst=%h pc4=%h req=%b, required 1 0 20080005 00400004 0",
               bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if, bus.imem_req);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.valid_if !== 1'b0 || bus.inst_if !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004) begin
      miscompares++;
      $display("FAIL basic_next_req: valid=%b inst=%h req=%b addr=%h, required 0 0 1 00400004",
               bus.valid_if, bus.inst_if, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hA5A5_0001;
    tick();
    bus.imem_resp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.stall_id = (k < 3);
      @(negedge clk);
      vectors++;
      if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if} !== {2'b10, 32'hA5A5_0001, RESET_PC + 32'd4}
          || bus.imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc4=%h req=%b, required 1 a5a50001 %h 0",
                 k, bus.valid_if, bus.inst_if, bus.pc4_if, bus.imem_req, RESET_PC + 32'd4);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (bus.valid_if !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC + 32'd4) begin
      miscompares++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, required 0 1 %h",
               bus.valid_if, bus.imem_req, bus.imem_addr, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick();
    for (int k = 1; k <= 3; k++) begin
      bus.redirect_valid  = (k == 1);
      bus.redirect_pc     = 32'h0040_0100;
      bus.imem_resp_valid = (k == 3);
      bus.imem_resp_data  = 32'h1111_1111;
      @(negedge clk);
      vectors++;
      if (bus.imem_req !== 1'b0 || bus.valid_if !== 1'b0) begin
        miscompares++;
        $display("FAIL redir_wait[%0d]: req=%b valid=%b, required 0 0", k, bus.imem_req, bus.valid_if);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (bus.valid_if !== 1'b0 || bus.inst_if !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0100) begin
      miscompares++;
      $display("FAIL redir_wait_refetch: valid=%b inst=%h req=%b addr=%h, required 0 0 1 00400100",
               bus.valid_if, bus.inst_if, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = HALT_WORD;
    tick();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if} !== {2'b11, HALT_WORD}) begin
      miscompares++;
      $display("FAIL halt_present: valid=%b halted=%b inst=%h, required 1 1 %h",
               bus.valid_if, bus.halted_if, bus.inst_if, HALT_WORD);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      bus.redirect_valid  = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.redirect_pc     = $urandom;
      bus.stall_id        = 1'($urandom_range(0, 1));
      bus.imem_resp_valid = 1'($urandom_range(0, 1));
      bus.imem_resp_data  = $urandom;
      @(negedge clk);
      vectors++;
      if (bus.valid_if !== 1'b0 || bus.halted_if !== 1'b1 || bus.imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_sticky[%0d]: valid=%b halted=%b req=%b, required 0 1 0",
                 k, bus.valid_if, bus.halted_if, bus.imem_req);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_halt_redirect();
    do_reset();
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = HALT_WORD;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_pc     = 32'h0040_0200;
    bus.stall_id        = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if} !== {2'b11, HALT_WORD}) begin
      miscompares++;
      $display("FAIL halt_redir_present: valid=%b halted=%b inst=%h, required 1 1 %h",
               bus.valid_if, bus.halted_if, bus.inst_if, HALT_WORD);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if} !== 34'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0200) begin
      miscompares++;
      $display("FAIL halt_redir_flush: valid=%b halted=%b inst=%h req=%b addr=%h, required 0 0 0 1 00400200",
               bus.valid_if, bus.halted_if, bus.inst_if, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_fetch_redirect: req=%b, required 0", bus.imem_req);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_aligned_req: req=%b addr=%h, required 1 fffffffc", bus.imem_req, bus.imem_addr);
    end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h3333_3333;
    tick();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if} !== {2'b10, 32'h3333_3333, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_pc4: valid=%b inst=%h pc4=%h, required 1 33333333 00000000",
               bus.valid_if, bus.inst_if, bus.pc4_if);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next_req: req=%b addr=%h, required 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    rst_b = 1'b1;
    #1;
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if, bus.imem_req} !== 67'h0) begin
      miscompares++;
      $display("FAIL midwait_async_reset: valid=%b inst=%h pc4=%h req=%b, required all 0",
               bus.valid_if, bus.inst_if, bus.pc4_if, bus.imem_req);
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h4444_4444;
    tick();
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.valid_if !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_refetch: req=%b addr=%h valid=%b, required 1 %h 0",
               bus.imem_req, bus.imem_addr, bus.valid_if, RESET_PC);
    end
    tick();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.valid_if !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_stale_dropped: valid=%b inst=%h, required 0", bus.valid_if, bus.inst_if);
    end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h5555_5555;
    tick();
    bus.imem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if} !== {2'b10, 32'h5555_5555, RESET_PC + 32'd4}) begin
      miscompares++;
      $display("FAIL midwait_fresh: valid=%b inst=%h pc4=%h, required 1 55555555 %h",
               bus.valid_if, bus.inst_if, bus.pc4_if, RESET_PC + 32'd4);
    end
  endtask

  // Random run. The model tracks the instruction stream, not the FSM:
  // the next request goes to the latest redirect target, else to the previous
  // request address + 4; a response is presented unless a redirect occurred
  // after its request (inclusive of the response cycle); a presented word
  // stays until a cycle without stall or with a redirect; with nothing
  // outstanding or presented the unit must request unless redirected.
  task automatic test_random(input int cycles);
    logic [31:0] exp_addr;
    logic [31:0] req_addr;
    logic [31:0] rpc;
    logic [31:0] exp_q[$];
    logic [31:0] pc4_q[$];
    logic        pending;
    logic        killed;
    logic        resp_now;
    logic        redir_now;
    logic        accept;
    logic        exp_req;
    int          due;
    int          requests;
    exp_addr = RESET_PC;
    req_addr = 32'h0;
    pending  = 1'b0;
    killed   = 1'b0;
    due      = 0;
    requests = 0;
    do_reset();
    for (int t = 0; t < cycles; t++) begin
      resp_now  = pending && (due == t);
      redir_now = ($urandom_range(0, 9) == 0);
      rpc       = $urandom;
      bus.imem_resp_valid = resp_now;
      bus.imem_resp_data  = resp_now ? mem_word(req_addr) : $urandom;
      bus.stall_id        = ($urandom_range(0, 2) == 0);
      bus.redirect_valid  = redir_now;
      bus.redirect_pc     = rpc;
      @(negedge clk);

      vectors++;
      if (exp_q.size() != 0) begin
        if ({bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if} !== {2'b10, exp_q[0], pc4_q[0]}) begin
          miscompares++;
          $display("FAIL rand_present t=%0d: valid=%b halted=%b inst=%h pc4=%h, required 1 0 %h %h",
                   t, bus.valid_if, bus.halted_if, bus.inst_if, bus.pc4_if, exp_q[0], pc4_q[0]);
        end
      end else if ({bus.valid_if, bus.halted_if, bus.inst_if} !== 34'h0) begin
        miscompares++;
        $display("FAIL rand_bubble t=%0d: valid=%b halted=%b inst=%h, required 0 0 0",
                 t, bus.valid_if, bus.halted_if, bus.inst_if);
      end

      exp_req = !pending && (exp_q.size() == 0) && !redir_now;
      vectors++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        miscompares++;
        $display("FAIL rand_request t=%0d: req=%b addr=%h, required %b %h",
                 t, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end

      if (exp_req) begin
        pending  = 1'b1;
        killed   = 1'b0;
        req_addr = exp_addr;
        due      = t + int'($urandom_range(1, 3));
        exp_addr = exp_addr + 32'd4;
        requests++;
      end
      accept = resp_now && !killed && !redir_now;
      if (resp_now) pending = 1'b0;
      if (redir_now) begin
        exp_addr = {rpc[31:2], 2'b00};
        killed   = 1'b1;
      end
      if (exp_q.size() != 0 && (redir_now || !bus.stall_id)) begin
        void'(exp_q.pop_front());
        void'(pc4_q.pop_front());
      end
      if (accept) begin
        exp_q.push_back(mem_word(req_addr));
        pc4_q.push_back(req_addr + 32'd4);
      end
      tick();
    end
    idle_inputs();
    vectors++;
    if (requests < cycles / 20) begin
      miscompares++;
      $display("FAIL rand_progress: %0d requests, required at least %0d", requests, cycles / 20);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_halt_redirect();
    test_wrap();
    test_reset_mid_wait();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
